note_scroller: RTL and testbench

Parametrised multi-lane note engine for the rhythm-game datapath. It generalises the single-column note position counter in three ways: any number of lanes, several notes in flight per lane, and a per-frame scroll speed. It also adds hit and miss judgement against a target line, plus a saturating score. It sits between the song sequencer (spawn pulses), the pad/button debouncers (press pulses) and the VGA renderer (note positions and valid flags).

---
 rtl/note_scroller.sv | 127 ++++++++++++
 tb/tb_note_scroller.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_scroller.sv
// Multi-lane note engine: per-slot scroll, hit/whiff/miss/drop judgement and a saturating score.
// Latency 1 (all outputs registered); no backpressure, every input pulse is consumed in its cycle.
module note_scroller #(
  parameter int LANES    = 4,
  parameter int SLOTS    = 4,
  parameter int POS_W    = 11,
  parameter int SCREEN_H = 1080,
  parameter int TARGET_Y = 900,
  parameter int HIT_WIN  = 40
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frame,
  input  logic [2:0]                     speed,
  input  logic [LANES-1:0]               spawn,
  input  logic [LANES-1:0]               press,
  output logic [LANES*SLOTS*POS_W-1:0]   pos,
  output logic [LANES*SLOTS-1:0]         valid,
  output logic [LANES-1:0]               hit,
  output logic [LANES-1:0]               miss,
  output logic [LANES-1:0]               whiff,
  output logic [LANES-1:0]               drop,
  output logic [15:0]                    score
);

  localparam int N = LANES * SLOTS;
  localparam logic [POS_W:0]   LIM    = (POS_W+1)'(SCREEN_H);
  localparam logic [POS_W-1:0] WIN_LO = POS_W'(TARGET_Y - HIT_WIN);
  localparam logic [POS_W-1:0] WIN_HI = POS_W'(TARGET_Y + HIT_WIN);

  logic [POS_W-1:0] pos_q [N];
  logic [POS_W-1:0] pos_d [N];
  logic [N-1:0]     valid_d;
  logic [LANES-1:0] hit_d, miss_d, whiff_d, drop_d;
  logic [15:0]      score_d;
  logic [16:0]      tot;
  logic [POS_W:0]   sum;
  logic             found, placed;
  int               best;

  always_comb begin
    for (int i = 0; i < N; i++) pos_d[i] = pos_q[i];
    valid_d = valid;
    hit_d   = '0;
    miss_d  = '0;
    whiff_d = '0;
    drop_d  = '0;
    tot     = {1'b0, score};
    sum     = '0;
    found   = 1'b0;
    placed  = 1'b0;
    best    = 0;
    for (int l = 0; l < LANES; l++) begin
      // Press: strict '>' keeps the lowest index on equal positions.
      found = 1'b0;
      best  = 0;
      if (press[l]) begin
        for (int s = 0; s < SLOTS; s++) begin
          if (valid[l*SLOTS+s] && pos_q[l*SLOTS+s] >= WIN_LO && pos_q[l*SLOTS+s] <= WIN_HI &&
              (!found || pos_q[l*SLOTS+s] > pos_q[l*SLOTS+best])) begin
            found = 1'b1;
            best  = s;
          end
        end
        if (found) begin
          valid_d[l*SLOTS+best] = 1'b0;
          hit_d[l] = 1'b1;
          tot = tot + 17'd1;
        end else begin
          whiff_d[l] = 1'b1;
        end
      end
      // Frame: valid_d already excludes the slot just hit.
      if (frame) begin
        for (int s = 0; s < SLOTS; s++) begin
          if (valid_d[l*SLOTS+s]) begin
            sum = {1'b0, pos_q[l*SLOTS+s]} + (POS_W+1)'(speed);
            if (sum >= LIM) begin
              valid_d[l*SLOTS+s] = 1'b0;
              miss_d[l] = 1'b1;
            end else begin
              pos_d[l*SLOTS+s] = sum[POS_W-1:0];
            end
          end
        end
      end
      // Spawn only into slots free at cycle start, so freed slots wait a cycle.
      placed = 1'b0;
      if (spawn[l]) begin
        for (int s = 0; s < SLOTS; s++) begin
          if (!valid[l*SLOTS+s] && !placed) begin
            placed = 1'b1;
            valid_d[l*SLOTS+s] = 1'b1;
            pos_d[l*SLOTS+s] = '0;
          end
        end
        if (!placed) drop_d[l] = 1'b1;
      end
    end
    score_d = tot[16] ? 16'hFFFF : tot[15:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) pos_q[i] <= '0;
      valid <= '0;
      hit   <= '0;
      miss  <= '0;
      whiff <= '0;
      drop  <= '0;
      score <= '0;
    end else begin
      for (int i = 0; i < N; i++) pos_q[i] <= pos_d[i];
      valid <= valid_d;
      hit   <= hit_d;
      miss  <= miss_d;
      whiff <= whiff_d;
      drop  <= drop_d;
      score <= score_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_pos
    assign pos[i*POS_W +: POS_W] = pos_q[i];
  end

endmodule

// File: tb/tb_note_scroller.sv
// Bench for note_scroller: directed scenarios plus randomized traffic against a lane/note model.
// Every tick compares the full DUT state against the model, one cycle after inputs are applied.
// Stimulus only; the bench never backpressures the design.
module tb_note_scroller;
    localparam int LANES = 4;
    localparam int SLOTS = 4;
    localparam int POS_W = 11;
    localparam int SCR_H = 1080;
    localparam int WLO   = 860;
    localparam int WHI   = 940;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic frame = 1'b0;
    logic [2:0] speed = 3'd0;
    logic [LANES-1:0] spawn = '0, press = '0;
    logic [LANES*SLOTS*POS_W-1:0] pos;
    logic [LANES*SLOTS-1:0] valid;
    logic [LANES-1:0] hit, miss, whiff, drop;
    logic [15:0] score;

    logic [LANES-1:0] s_spawn = '0, s_press = '0;
    logic [LANES*SLOTS*POS_W-1:0] s_pos;
    logic [LANES*SLOTS-1:0] s_valid;
    logic [LANES-1:0] s_hit, s_miss, s_whiff, s_drop;
    logic [15:0] s_score;

    int errors = 0;
    int checks = 0;

    int m_pos [LANES][SLOTS];
    bit m_val [LANES][SLOTS];
    logic [LANES-1:0] m_hit, m_miss, m_whiff, m_drop;
    int m_score;

    always #5 clk = ~clk;

    note_scroller #(.LANES(LANES), .SLOTS(SLOTS), .POS_W(POS_W), .SCREEN_H(1080),
                    .TARGET_Y(900), .HIT_WIN(40)) dut (
        .clk(clk), .rst(rst), .frame(frame), .speed(speed), .spawn(spawn), .press(press),
        .pos(pos), .valid(valid), .hit(hit), .miss(miss), .whiff(whiff), .drop(drop), .score(score));

    // Window [0,80] lets notes be hit right after spawning, to reach saturation quickly.
    note_scroller #(.LANES(LANES), .SLOTS(SLOTS), .POS_W(POS_W), .SCREEN_H(1080),
                    .TARGET_Y(40), .HIT_WIN(40)) sat (
        .clk(clk), .rst(rst), .frame(1'b0), .speed(3'd0), .spawn(s_spawn), .press(s_press),
        .pos(s_pos), .valid(s_valid), .hit(s_hit), .miss(s_miss), .whiff(s_whiff), .drop(s_drop),
        .score(s_score));

    function automatic int dpos(input int l, input int s);
        return int'(pos[(l*SLOTS+s)*POS_W +: POS_W]);
    endfunction

    function automatic bit dval(input int l, input int s);
        return valid[l*SLOTS+s];
    endfunction

    task automatic expect_true(input bit cond, input string msg);
        checks++;
        if (!cond) begin
            errors++;
            $display("FAIL %s", msg);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < LANES; l++)
            for (int s = 0; s < SLOTS; s++) begin
                m_pos[l][s] = 0;
                m_val[l][s] = 0;
            end
        m_hit = '0; m_miss = '0; m_whiff = '0; m_drop = '0;
        m_score = 0;
    endtask

    task automatic model_step(input bit f, input int sp, input logic [LANES-1:0] sw,
                              input logic [LANES-1:0] pr);
        int hits;
        hits = 0;
        m_hit = '0; m_miss = '0; m_whiff = '0; m_drop = '0;
        for (int l = 0; l < LANES; l++) begin
            bit was [SLOTS];
            int pick;
            bit spawned;
            for (int s = 0; s < SLOTS; s++) was[s] = m_val[l][s];
            if (pr[l]) begin
                pick = -1;
                for (int s = 0; s < SLOTS; s++)
                    if (m_val[l][s] && m_pos[l][s] >= WLO && m_pos[l][s] <= WHI)
                        if (pick < 0 || m_pos[l][s] > m_pos[l][pick]) pick = s;
                if (pick >= 0) begin
                    m_val[l][pick] = 0;
                    m_hit[l] = 1'b1;
                    hits++;
                end else m_whiff[l] = 1'b1;
            end
            if (f)
                for (int s = 0; s < SLOTS; s++)
                    if (m_val[l][s]) begin
                        if (m_pos[l][s] + sp >= SCR_H) begin
                            m_val[l][s] = 0;
                            m_miss[l] = 1'b1;
                        end else m_pos[l][s] += sp;
                    end
            if (sw[l]) begin
                spawned = 0;
                for (int s = 0; s < SLOTS; s++)
                    if (!was[s] && !spawned) begin
                        spawned = 1;
                        m_val[l][s] = 1;
                        m_pos[l][s] = 0;
                    end
                if (!spawned) m_drop[l] = 1'b1;
            end
        end
        m_score = (m_score + hits > 65535) ? 65535 : m_score + hits;
    endtask

    task automatic compare();
        for (int l = 0; l < LANES; l++)
            for (int s = 0; s < SLOTS; s++) begin
                checks++;
                if (dval(l, s) !== m_val[l][s] || dpos(l, s) != m_pos[l][s]) begin
                    errors++;
                    $display("FAIL slot l=%0d s=%0d valid=%0b pos=%0d required valid=%0b pos=%0d",
                             l, s, dval(l, s), dpos(l, s), m_val[l][s], m_pos[l][s]);
                end
            end
        checks++;
        if (hit !== m_hit || miss !== m_miss || whiff !== m_whiff || drop !== m_drop) begin
            errors++;
            $display("FAIL pulses hit=%b miss=%b whiff=%b drop=%b required %b %b %b %b",
                     hit, miss, whiff, drop, m_hit, m_miss, m_whiff, m_drop);
        end
        checks++;
        if (int'(score) != m_score) begin
            errors++;
            $display("FAIL score=%0d required %0d", score, m_score);
        end
    endtask

    task automatic tick(input bit f, input logic [2:0] sp, input logic [LANES-1:0] sw,
                        input logic [LANES-1:0] pr);
        frame = f; speed = sp; spawn = sw; press = pr;
        @(posedge clk);
        model_step(f, int'(sp), sw, pr);
        #1;
        frame = 1'b0; spawn = '0; press = '0;
        compare();
    endtask

    task automatic frames(input int n, input logic [2:0] sp);
        for (int i = 0; i < n; i++) tick(1'b1, sp, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        spawn = '1; press = '1; frame = 1'b1; speed = 3'd5;
        @(posedge clk); @(posedge clk); #1;
        expect_true(valid === '0 && pos === '0, "reset_state valid/pos not zero");
        expect_true({hit, miss, whiff, drop} === '0 && score === 16'd0, "reset_pulses/score not zero");
        spawn = '0; press = '0; frame = 1'b0;
        @(negedge clk); rst = 1'b1;
        tick(1'b0, 3'd0, '0, '0);
        expect_true({hit, miss, whiff, drop} === '0, "stale pulse after reset release");
    endtask

    task automatic test_basic_hit();
        tick(1'b0, 3'd7, 4'b0001, '0);
        frames(128, 3'd7);
        expect_true(dval(0, 0) && dpos(0, 0) == 896, "basic_hit pos not 896");
        tick(1'b0, 3'd7, '0, 4'b0001);
        expect_true(hit[0] === 1'b1 && !dval(0, 0) && score == 16'd1, "basic_hit no hit/score");
        tick(1'b0, 3'd7, '0, '0);
        expect_true(hit[0] === 1'b0, "basic_hit pulse wider than one cycle");
    endtask

    task automatic test_expiry();
        tick(1'b0, 3'd7, 4'b0010, '0);
        frames(154, 3'd7);
        expect_true(dval(1, 0) && dpos(1, 0) == 1078, "expiry pos not 1078");
        tick(1'b1, 3'd7, '0, '0);
        expect_true(miss[1] === 1'b1 && !dval(1, 0) && score == 16'd1, "expiry no miss");
        tick(1'b0, 3'd7, '0, '0);
        expect_true(miss[1] === 1'b0, "expiry pulse wider than one cycle");
    endtask

    task automatic test_whiff();
        tick(1'b0, 3'd0, 4'b0100, '0);
        tick(1'b0, 3'd0, '0, 4'b0100);
        expect_true(whiff[2] === 1'b1 && hit[2] === 1'b0 && dval(2, 0) && dpos(2, 0) == 0,
                    "whiff at pos 0");
        tick(1'b0, 3'd0, '0, 4'b1000);
        expect_true(whiff[3] === 1'b1, "whiff on empty lane");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) tick(1'b0, 3'd0, 4'b1000, '0);
        expect_true(drop[3] === 1'b1 && valid[15:12] === 4'b1111, "overflow drop");
        frames(128, 3'd7);
        tick(1'b0, 3'd0, 4'b1000, 4'b1000);
        expect_true(hit[3] === 1'b1 && drop[3] === 1'b1 && !dval(3, 0), "hit+spawn same cycle");
        tick(1'b0, 3'd0, 4'b1000, '0);
        expect_true(dval(3, 0) && dpos(3, 0) == 0 && drop[3] === 1'b0, "reuse slot 0");
    endtask

    task automatic test_priority();
        tick(1'b0, 3'd5, 4'b0001, '0);
        frames(8, 3'd5);
        tick(1'b0, 3'd5, 4'b0001, '0);
        frames(176, 3'd5);
        expect_true(dpos(0, 0) == 920 && dpos(0, 1) == 880, "priority setup 920/880");
        tick(1'b0, 3'd5, '0, 4'b0001);
        expect_true(hit[0] === 1'b1 && !dval(0, 0) && dval(0, 1), "oldest-first press");
        do_reset();
        for (int i = 0; i < 4; i++) tick(1'b0, 3'd0, 4'b0001, '0);
        frames(128, 3'd7);
        tick(1'b1, 3'd3, 4'b0001, 4'b0001);
        expect_true(hit[0] === 1'b1 && drop[0] === 1'b1 && dpos(0, 1) == 899,
                    "press+frame+spawn on full lane");
    endtask

    task automatic test_random();
        logic [LANES-1:0] sw, pr;
        for (int i = 0; i < 3000; i++) begin
            sw = 4'($urandom) & 4'($urandom);
            pr = 4'($urandom) & 4'($urandom) & 4'($urandom);
            tick(1'($urandom), 3'($urandom), sw, pr);
        end
    endtask

    task automatic test_saturation();
        s_spawn = '1; s_press = '1;
        repeat (17000) @(posedge clk);
        #1;
        expect_true(s_score === 16'hFFFF, "score not saturated");
        @(posedge clk); #1;
        expect_true(s_score === 16'hFFFF && s_hit === 4'b1111, "score wrapped after saturation");
        s_spawn = '0; s_press = '0;
    endtask

    task automatic test_mid_reset();
        tick(1'b0, 3'd0, 4'b1111, '0);
        frames(10, 3'd4);
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        expect_true(valid === '0 && pos === '0 && score === 16'd0 &&
                    {hit, miss, whiff, drop} === '0, "async mid reset");
        model_reset();
        @(negedge clk); rst = 1'b1;
        tick(1'b0, 3'd0, '0, '0);
    endtask

    initial begin
        model_reset();
        do_reset();
        test_basic_hit();
        test_expiry();
        test_whiff();
        test_overflow();
        do_reset();
        test_priority();
        do_reset();
        test_random();
        test_mid_reset();
        do_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
